mult4b_seq: RTL and testbench

//   Sequential 4x4 unsigned shift-and-add multiplier built around the 4-bit ripple adder (sum4b).

---
 rtl/mult4b_seq.sv | 105 ++++++++++
 tb/tb_mult4b_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mult4b_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving a 4-bit ripple adder.
// Operands captured on init in IDLE; product on PP with a one-cycle done pulse 8 edges later.

module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sum4b (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co
);
  logic [4:0] c;

  assign c[0] = Ci;
  assign Co   = c[4];

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      fa1 u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(S[i]), .co(c[i+1]));
    end
  endgenerate
endmodule

module mult4b_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] PP,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] md, acc, mr;
  logic       c;
  logic [1:0] cnt;
  logic [3:0] sum;
  logic       co;

  sum4b u_add (.A(acc), .B(md), .Ci(1'b0), .S(sum), .Co(co));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == 2'd3) ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md  <= '0;
      acc <= '0;
      mr  <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (init) begin
          md  <= A;
          mr  <= B;
          acc <= '0;
          c   <= 1'b0;
          cnt <= '0;
        end
        ADD: begin
          // Add slot is always consumed so latency is data-independent
          if (mr[0]) {c, acc} <= {co, sum};
          else       c <= 1'b0;
        end
        SHIFT: begin
          {c, acc, mr} <= {1'b0, c, acc, mr[3:1]};
          cnt          <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign PP   = {acc, mr};
  assign busy = (state == ADD) || (state == SHIFT);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mult4b_seq.sv
// Directed + randomized bench for mult4b_seq, checked against plain A*B arithmetic.

module tb_mult4b_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [7:0] PP;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mult4b_seq dut (.clk(clk), .rst_n(rst_n), .init(init), .A(A), .B(B),
                  .PP(PP), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; optionally disturbs A/B/init while busy.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit disturb, input string tag);
    logic [7:0] exp;
    exp = 8'(a) * 8'(b);
    @(negedge clk);
    A = a; B = b; init = 1'b1;
    tick();
    init = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, " busy"}, {7'b0, busy}, 8'd1);
      check({tag, " done early"}, {7'b0, done}, 8'd0);
      if (disturb) begin
        A = 4'($urandom);
        B = 4'($urandom);
        init = 1'($urandom);
      end
      tick();
    end
    init = 1'b0;
    check({tag, " done"}, {7'b0, done}, 8'd1);
    check({tag, " busy at done"}, {7'b0, busy}, 8'd0);
    check({tag, " PP"}, PP, exp);
    tick();
    check({tag, " done pulse width"}, {7'b0, done}, 8'd0);
    check({tag, " PP held"}, PP, exp);
  endtask

  initial begin
    logic [3:0] ea, eb;
    int last_done;
    bit seen;

    // 1. reset state
    #2;
    check("reset PP", PP, 8'h00);
    check("reset busy", {7'b0, busy}, 8'd0);
    check("reset done", {7'b0, done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle busy", {7'b0, busy}, 8'd0);
      check("idle PP", PP, 8'h00);
    end

    // 2/3. directed products including the carry path
    run_op(4'd5, 4'd3, 1'b0, "5x3");
    run_op(4'd15, 4'd15, 1'b0, "15x15");
    run_op(4'd15, 4'd8, 1'b0, "15x8");
    run_op(4'd0, 4'd9, 1'b0, "0x9");

    // 4. interference while busy
    run_op(4'd11, 4'd13, 1'b1, "disturb");

    // 5. reset mid-operation
    @(negedge clk);
    A = 4'd7; B = 4'd6; init = 1'b1;
    tick();
    init = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset PP", PP, 8'h00);
    check("midreset busy", {7'b0, busy}, 8'd0);
    check("midreset done", {7'b0, done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("no done after reset", {7'b0, seen}, 8'd0);
    run_op(4'd7, 4'd6, 1'b0, "7x6 after reset");

    // randomized operations
    for (int k = 0; k < 20; k++)
      run_op(4'($urandom), 4'($urandom), 1'($urandom), "random");

    // 6. exhaustive, init held high
    @(negedge clk);
    A = 4'd0; B = 4'd0; init = 1'b1;
    last_done = -1;
    for (int p = 0; p < 256; p++) begin
      ea = 4'(p >> 4);
      eb = 4'(p);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check("exh done timeout", {7'b0, seen}, 8'd1);
      if (!seen) break;
      check("exh PP", PP, 8'(ea) * 8'(eb));
      if (last_done >= 0) check("exh spacing", 8'(cyc - last_done), 8'd10);
      last_done = cyc;
      A = 4'((p + 1) >> 4);
      B = 4'(p + 1);
    end
    init = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
